// File: rtl/sdram_responder.sv
// Behavioural SDRAM controller stand-in: word-addressed RAM behind an Avalon-style port with active-low strobes.
// Latency: read data returns READ_LATENCY cycles after accept, in order; writes land at the accept edge.
// Backpressure: waitrequest (registers only) during refresh, at MAX_PENDING reads, and on LFSR stalls if SDRAM_RESP_RANDOM_STALL_EN.
module sdram_responder #(
    parameter int ADDR_W         = 25,
    parameter int DATA_W         = 16,
    parameter int MEM_AW         = 10,
    parameter int READ_LATENCY   = 3,
    parameter int MAX_PENDING    = 2,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] sdram_address,
    input  logic [1:0]        sdram_byteenable_n,
    input  logic              sdram_chipselect,
    input  logic [DATA_W-1:0] sdram_writedata,
    input  logic              sdram_read_n,
    input  logic              sdram_write_n,
    output logic [DATA_W-1:0] sdram_readdata,
    output logic              sdram_readdatavalid,
    output logic              sdram_waitrequest,
    output logic              refresh_active,
    output logic              err_collision
);
    localparam int LANE_W = DATA_W / 2;
    localparam int PCW    = $clog2(MAX_PENDING + 1);
    localparam int CNT_MAX = (REFRESH_PERIOD > REFRESH_CYCLES) ? REFRESH_PERIOD : REFRESH_CYCLES;
    localparam int CW     = $clog2(CNT_MAX + 1);

    typedef enum logic {ST_NORMAL, ST_REFRESH} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [PCW-1:0]      r_pend;
    logic [READ_LATENCY-1:0] r_dl_vld;
    logic [DATA_W-1:0]   r_dl_dat [READ_LATENCY];
    logic [DATA_W-1:0]   r_mem [2**MEM_AW];
    logic                r_err;
    logic                w_wait;
    logic                w_acc_rd;
    logic                w_acc_wr;
    logic                w_collide;
    logic [MEM_AW-1:0]   w_idx;
    logic                w_unused_addr;

    assign w_idx         = sdram_address[MEM_AW-1:0];
    assign w_unused_addr = ^sdram_address[ADDR_W-1:MEM_AW];

`ifdef SDRAM_RESP_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) that injects pseudo-random stalls
    always_ff @(posedge clk) begin
        if (reset) r_lfsr <= 16'hACE1;
        else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign w_wait = (r_state == ST_REFRESH) || (r_pend == PCW'(MAX_PENDING)) || (r_lfsr[1:0] == 2'b00);
`else
    assign w_wait = (r_state == ST_REFRESH) || (r_pend == PCW'(MAX_PENDING));
`endif

    assign w_collide = sdram_chipselect && !sdram_read_n && !sdram_write_n;
    assign w_acc_rd  = sdram_chipselect && !w_wait && !sdram_read_n && sdram_write_n;
    assign w_acc_wr  = sdram_chipselect && !w_wait && sdram_read_n && !sdram_write_n;

    assign sdram_waitrequest   = w_wait;
    assign refresh_active      = (r_state == ST_REFRESH);
    assign sdram_readdatavalid = r_dl_vld[READ_LATENCY-1];
    assign sdram_readdata      = r_dl_dat[READ_LATENCY-1];
    assign err_collision       = r_err;

    // Refresh scheduler: one counter times both the normal period and the refresh stall
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        case (r_state)
            ST_NORMAL: begin
                if (r_cnt == CW'(REFRESH_PERIOD - 1)) begin
                    w_state_nxt = ST_REFRESH;
                    w_cnt_nxt   = '0;
                end
            end
            ST_REFRESH: begin
                if (r_cnt == CW'(REFRESH_CYCLES - 1)) begin
                    w_state_nxt = ST_NORMAL;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_NORMAL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_NORMAL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Backing store: per-lane writes, contents survive reset
    always_ff @(posedge clk) begin
        if (w_acc_wr) begin
            for (int b = 0; b < 2; b++) begin
                if (!sdram_byteenable_n[b]) r_mem[w_idx][b*LANE_W +: LANE_W] <= sdram_writedata[b*LANE_W +: LANE_W];
            end
        end
    end

    // Read delay line; each stage's data only moves with a valid beat so the last stage holds readdata
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dl_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) r_dl_dat[i] <= '0;
        end else begin
            r_dl_vld[0] <= w_acc_rd;
            if (w_acc_rd) r_dl_dat[0] <= r_mem[w_idx];
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                if (r_dl_vld[i-1]) r_dl_dat[i] <= r_dl_dat[i-1];
            end
        end
    end

    // Outstanding-read count and sticky collision flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
            r_err  <= 1'b0;
        end else begin
            case ({w_acc_rd, r_dl_vld[READ_LATENCY-1]})
                2'b10:   r_pend <= r_pend + PCW'(1);
                2'b01:   r_pend <= r_pend - PCW'(1);
                default: r_pend <= r_pend;
            endcase
            if (w_collide) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sdram_responder.sv
// Randomised and directed stimulus for sdram_responder, scored against a cycle-indexed reference model.
// Latency: model predicts each output per cycle; reads due READ_LATENCY cycles after accept.
// Backpressure: model derives waitrequest from refresh schedule arithmetic and outstanding-read count.
module tb_sdram_responder;
    localparam int LAT = 3;
    localparam int MP  = 2;
    localparam int PER = 64;
    localparam int RC  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] sdram_address;
    logic [1:0]  sdram_byteenable_n;
    logic        sdram_chipselect;
    logic [15:0] sdram_writedata;
    logic        sdram_read_n;
    logic        sdram_write_n;
    logic [15:0] sdram_readdata;
    logic        sdram_readdatavalid;
    logic        sdram_waitrequest;
    logic        refresh_active;
    logic        err_collision;

    always #5 clk = ~clk;

    sdram_responder dut (
        .clk                 (clk),
        .reset               (reset),
        .sdram_address       (sdram_address),
        .sdram_byteenable_n  (sdram_byteenable_n),
        .sdram_chipselect    (sdram_chipselect),
        .sdram_writedata     (sdram_writedata),
        .sdram_read_n        (sdram_read_n),
        .sdram_write_n       (sdram_write_n),
        .sdram_readdata      (sdram_readdata),
        .sdram_readdatavalid (sdram_readdatavalid),
        .sdram_waitrequest   (sdram_waitrequest),
        .refresh_active      (refresh_active),
        .err_collision       (err_collision)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;

    rsp_t        q[$];
    logic [15:0] cap[$];
    logic [15:0] mem [0:1023];
    int          c;
    bit          m_err;
    logic [15:0] m_last;
    bit          m_acc;
    int          last_vld_c;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, c);
    endtask

    // One bus cycle: drive at posedge+1, score at posedge+4, then advance the model
    task automatic do_cycle(input logic cs, input logic rd_n, input logic wr_n,
                            input logic [1:0] be, input logic [24:0] a, input logic [15:0] wd);
        bit ref_on, w, ev;
        int idx;
        sdram_chipselect   = cs;
        sdram_read_n       = rd_n;
        sdram_write_n      = wr_n;
        sdram_byteenable_n = be;
        sdram_address      = a;
        sdram_writedata    = wd;
        #3;
        ref_on = (c >= PER) && (((c - PER) % (PER + RC)) < RC);
        w      = ref_on || (q.size() == MP);
        ev     = (q.size() > 0) && (q[0].due == c);
        if (ev) m_last = q[0].data;
        check_val("waitrequest", 32'(sdram_waitrequest), 32'(w));
        check_val("refresh_active", 32'(refresh_active), 32'(ref_on));
        check_val("readdatavalid", 32'(sdram_readdatavalid), 32'(ev));
        check_val("readdata", 32'(sdram_readdata), 32'(m_last));
        check_val("err_collision", 32'(err_collision), 32'(m_err));
        if (sdram_readdatavalid) begin
            cap.push_back(sdram_readdata);
            last_vld_c = c;
        end
        if (ev) void'(q.pop_front());
        m_acc = cs && !w && (rd_n != wr_n);
        if (cs && !rd_n && !wr_n) m_err = 1'b1;
        idx = int'(a[9:0]);
        if (m_acc && !wr_n) begin
            if (!be[0]) mem[idx][7:0]  = wd[7:0];
            if (!be[1]) mem[idx][15:8] = wd[15:8];
        end
        if (m_acc && !rd_n) q.push_back('{due: c + LAT, data: mem[idx]});
        c++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b1, 1'b1, 2'b11, 25'd0, 16'd0);
    endtask

    // Hold a command until the model says it was taken; returns the accept cycle
    task automatic issue(input string tag, input logic rd_n, input logic wr_n, input logic [1:0] be,
                         input logic [24:0] a, input logic [15:0] wd, output int acc_c);
        bit got = 1'b0;
        acc_c = -1;
        for (int i = 0; i < 100 && !got; i++) begin
            do_cycle(1'b1, rd_n, wr_n, be, a, wd);
            if (m_acc) begin
                got   = 1'b1;
                acc_c = c - 1;
            end
        end
        check_val({tag, "_accepted"}, 32'(got), 32'd1);
    endtask

    task automatic wr(input logic [24:0] a, input logic [15:0] wd, input logic [1:0] be);
        int ac;
        issue("write", 1'b1, 1'b0, be, a, wd, ac);
    endtask

    // Read one word and report the data the DUT returned and its latency
    task automatic rd_word(input logic [24:0] a, output logic [15:0] d, output int lat);
        int ac;
        cap.delete();
        issue("read", 1'b0, 1'b1, 2'b11, a, 16'd0, ac);
        for (int i = 0; i < 20 && cap.size() == 0; i++) idle(1);
        check_val("read_returned", 32'(cap.size()), 32'd1);
        d   = (cap.size() > 0) ? cap[0] : 16'hxxxx;
        lat = last_vld_c - ac;
    endtask

    task automatic do_reset();
        sdram_chipselect   = 1'b0;
        sdram_read_n       = 1'b1;
        sdram_write_n      = 1'b1;
        sdram_byteenable_n = 2'b11;
        sdram_address      = '0;
        sdram_writedata    = '0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        c      = 0;
        q.delete();
        m_err  = 1'b0;
        m_last = 16'h0000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int          lat, a0, a1, a2;
        logic [24:0] ra;

        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        do_reset();

        // First refresh window and a write held off by it
        idle(65);
        issue("refresh_write", 1'b1, 1'b0, 2'b00, 25'h040, 16'h5555, a0);
        check_val("refresh_write_accept_cycle", 32'(a0), 32'd68);
        rd_word(25'h040, d, lat);
        check_val("refresh_readback", 32'(d), 32'h5555);

        // Basic write/read and latency
        wr(25'h010, 16'hBEEF, 2'b00);
        rd_word(25'h010, d, lat);
        check_val("beef_data", 32'(d), 32'hBEEF);
        check_val("beef_latency", 32'(lat), 32'(LAT));
        idle(1);

        // Byte-lane merge
        wr(25'h020, 16'h1234, 2'b00);
        wr(25'h020, 16'hABCD, 2'b10);
        wr(25'h030, 16'h0000, 2'b00);
        rd_word(25'h020, d, lat);
        check_val("lane_merge", 32'(d), 32'h12CD);

        // Back-to-back reads against the pending limit
        cap.delete();
        issue("b2b0", 1'b0, 1'b1, 2'b11, 25'h010, 16'd0, a0);
        issue("b2b1", 1'b0, 1'b1, 2'b11, 25'h020, 16'd0, a1);
        issue("b2b2", 1'b0, 1'b1, 2'b11, 25'h030, 16'd0, a2);
        check_val("b2b_second_gap", 32'(a1 - a0), 32'd1);
        check_val("b2b_third_gap", 32'(a2 - a0), 32'(LAT + 1));
        for (int i = 0; i < 20 && cap.size() < 3; i++) idle(1);
        check_val("b2b_count", 32'(cap.size()), 32'd3);
        if (cap.size() == 3) begin
            check_val("b2b_data0", 32'(cap[0]), 32'hBEEF);
            check_val("b2b_data1", 32'(cap[1]), 32'h12CD);
            check_val("b2b_data2", 32'(cap[2]), 32'h0000);
        end

        // Collision: flagged, sticky, memory untouched
        do_cycle(1'b1, 1'b0, 1'b0, 2'b00, 25'h010, 16'hFFFF);
        check_val("collision_set", 32'(err_collision), 32'd1);
        idle(3);
        check_val("collision_sticky", 32'(err_collision), 32'd1);
        rd_word(25'h010, d, lat);
        check_val("collision_mem_kept", 32'(d), 32'hBEEF);

        // Reset with a read in flight drops it
        issue("inflight", 1'b0, 1'b1, 2'b11, 25'h010, 16'd0, a0);
        do_reset();
        cap.delete();
        idle(8);
        check_val("inflight_dropped", 32'(cap.size()), 32'd0);
        check_val("err_cleared", 32'(err_collision), 32'd0);
        rd_word(25'h010, d, lat);
        check_val("post_reset_read", 32'(d), 32'hBEEF);

        // Random traffic over a known-content window with aliased upper address bits
        do_reset();
        for (int i = 0; i < 64; i++) begin
            ra = 25'($urandom());
            ra[9:0] = 10'(i);
            wr(ra, 16'($urandom()), 2'b00);
        end
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic cs, rn, wn;
            r  = int'($urandom_range(0, 31));
            cs = ($urandom_range(0, 3) != 0);
            rn = 1'b1;
            wn = 1'b1;
            if (r == 0) begin
                rn = 1'b0;
                wn = 1'b0;
            end else if (r < 14) rn = 1'b0;
            else if (r < 26) wn = 1'b0;
            ra = 25'($urandom());
            ra[9:6] = 4'd0;
            do_cycle(cs, rn, wn, 2'($urandom()), ra, 16'($urandom()));
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
Responder (target) side of the SDRAM controller port used by the user-side SDRAM access block: on-chip behavioural stand-in for the SDRAM controller.
- Accepts Avalon-style reads and writes with active-low strobes and byte enables.
- Backs them with a word-addressed RAM.
- Returns read data after a fixed pipelined latency.
- Inserts periodic refresh stalls on sdram_waitrequest.
- Used in FPGA bring-up and simulation wherever the real controller is absent.

Parameters:
ADDR_W, 25, command address width
DATA_W, 16, data width (two byte lanes)
MEM_AW, 10, backing store words = 2**MEM_AW; address bits above MEM_AW-1 ignored (aliasing)
READ_LATENCY, 3, cycles from read accept to readdatavalid (>=1)
MAX_PENDING, 2, max outstanding reads before stall (>=1)
REFRESH_PERIOD, 64, normal cycles between refreshes
REFRESH_CYCLES, 4, stall cycles per refresh

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
sdram_address  in  ADDR_W  word address
sdram_byteenable_n  in  2  byte-lane enable, active-low, bit0 = [7:0]
sdram_chipselect  in  1  command qualifier
sdram_writedata  in  DATA_W  write data
sdram_read_n  in  1  read strobe, active-low
sdram_write_n  in  1  write strobe, active-low
sdram_readdata  out  DATA_W  read data
sdram_readdatavalid  out  1  one-cycle pulse per read beat
sdram_waitrequest  out  1  command not accepted this cycle
refresh_active  out  1  high while in REFRESH
err_collision  out  1  sticky: read and write strobes asserted together

Behaviour:
- One clock, clk. Synchronous active-high reset, reset.
- Reset values: readdata 0, readdatavalid 0, waitrequest 0, refresh_active 0, err_collision 0. Pending count 0, refresh counter 0, delay line cleared, state NORMAL. RAM contents not cleared.
- waitrequest is decoded from registers only; no combinational path from inputs. waitrequest = (state==REFRESH) | (pending==MAX_PENDING).
- Accept (rising edge): chipselect & !waitrequest & exactly one of read_n/write_n low. One command per cycle.
- Write accept: each lane with byteenable_n bit 0 updates mem[address[MEM_AW-1:0]]; other lanes keep their value. byteenable_n=11 is accepted as a no-op.
- Read accept: full word read (byteenable ignored) and pushed into a READ_LATENCY-stage delay line.
  - Accept at edge N gives readdatavalid high for the cycle after edge N+READ_LATENCY-1, i.e. READ_LATENCY cycles later.
  - readdata is held between pulses.
  - Responses come back strictly in order.
- Read-after-write: a write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Pending counter:
  - +1 on read accept, -1 on valid pulse; simultaneous events leave it unchanged.
  - Never exceeds MAX_PENDING.
- Collision: chipselect with both strobes low → no accept and no memory change; err_collision set and held until reset. Both strobes high or chipselect low → idle.
- State machine NORMAL / REFRESH:
  - NORMAL: refresh counter increments each cycle; at REFRESH_PERIOD-1 → REFRESH, counter cleared.
  - REFRESH: stall counter runs REFRESH_CYCLES cycles with refresh_active=1 and waitrequest=1, then → NORMAL.
  - Reads already in the delay line complete during REFRESH.
  - With defaults, first refresh occupies cycles 64..67 after reset release.
- Reset mid-operation: in-flight reads are dropped (no valid pulse); counters and state reset.

Optional Feature:
SDRAM_RESP_RANDOM_STALL_EN
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded 16'hACE1 on reset, advancing every cycle.
  - waitrequest additionally asserted when lfsr[1:0]==2'b00.
  - Stall is deterministic per seed; refresh and pending rules are unchanged.
- Undefined: no LFSR; waitrequest exactly as in Behaviour.

Test Plan:
- Write 16'hBEEF @ 0x010 (byteenable_n 00), then read 0x010 → readdatavalid exactly 3 cycles after read accept, readdata 16'hBEEF, single-cycle pulse.
- Write 16'h1234 @ 0x020, then write 16'hABCD with byteenable_n 2'b10 → read 0x020 returns 16'h12CD.
- Reads 0x010, 0x020, 0x030 offered back-to-back (MAX_PENDING 2) → third held by waitrequest until first valid; data returned in order BEEF, 12CD, 0000.
- Idle after reset → waitrequest and refresh_active high cycles 64..67. Write 16'h5555 @ 0x040 presented at cycle 65 → accepted at cycle 68 edge; readback 16'h5555.
- chipselect=1 with read_n=write_n=0, writedata 16'hFFFF @ 0x010 → err_collision=1 and stays set; read 0x010 still returns 16'hBEEF.
- Read 0x010 accepted, reset pulsed 1 cycle later → no readdatavalid, pending 0; later read 0x010 returns 16'hBEEF.
